// File: rtl/p_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : p_dispatch_pkg
//  Purpose  : Shared types for the P (dispatch) stage: the renamed pair
//             handed over by R, the issue-queue slot packet, the ROB entry
//             written at dispatch and the issue-queue class routing helper.
//  Revision : 1.0  initial release
// ============================================================================
package p_dispatch_pkg;

  localparam int ROB_W      = 6;
  localparam int DATA_W     = 32;
  localparam int AREG_W     = 5;
  localparam int PC_W       = 32;
  localparam int ALU_TYPE_W = 4;
  localparam int MDU_TYPE_W = 3;
  localparam int LSU_TYPE_W = 3;
  localparam int CDB_N      = 2;

  typedef enum logic [1:0] {
    IQ_ALU = 2'd0,
    IQ_MDU = 2'd1,
    IQ_LSU = 2'd2
  } iq_class_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

  // One renamed instruction as delivered by R
  typedef struct packed {
    logic                         r_valid;
    logic [PC_W-1:0]              pc;
    logic [AREG_W-1:0]            areg;
    logic [ROB_W-1:0]             preg;
    logic                         w_reg;
    logic                         w_mem;
    logic                         check;
    logic [ALU_TYPE_W-1:0]        alu_type;
    logic [MDU_TYPE_W-1:0]        mdu_type;
    logic [LSU_TYPE_W-1:0]        lsu_type;
    logic [1:0][AREG_W-1:0]       src_areg;
    logic [1:0][ROB_W-1:0]        src_preg;
    logic [1:0][DATA_W-1:0]       arf_data;
    logic [1:0]                   data_valid;
    logic                         use_imm;
    logic [DATA_W-1:0]            data_imm;
  } r_p_slot_t;

  typedef struct packed {
    r_p_slot_t [1:0] slot;
  } r_p_pkg_t;

  // Slot packet presented to all three issue queues
  typedef struct packed {
    logic [PC_W-1:0]              pc;
    logic [ROB_W-1:0]             preg;
    logic [AREG_W-1:0]            areg;
    logic                         w_reg;
    logic                         w_mem;
    logic [ALU_TYPE_W-1:0]        alu_type;
    logic [MDU_TYPE_W-1:0]        mdu_type;
    logic [LSU_TYPE_W-1:0]        lsu_type;
    logic [1:0][ROB_W-1:0]        src_preg;
    logic [1:0][DATA_W-1:0]       opnd;
    logic [1:0]                   opnd_valid;
  } p_iq_pkg_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [AREG_W-1:0] areg;
    logic              w_reg;
    logic              w_mem;
    logic              check;
    logic              complete;
  } rob_entry_t;

  // Contents of the pair buffer: hazard and immediate already resolved
  typedef struct packed {
    logic                         r_valid;
    logic [PC_W-1:0]              pc;
    logic [AREG_W-1:0]            areg;
    logic [ROB_W-1:0]             preg;
    logic                         w_reg;
    logic                         w_mem;
    logic                         check;
    logic [ALU_TYPE_W-1:0]        alu_type;
    logic [MDU_TYPE_W-1:0]        mdu_type;
    logic [LSU_TYPE_W-1:0]        lsu_type;
    logic [1:0][ROB_W-1:0]        src_preg;
    logic [1:0][DATA_W-1:0]       opnd;
    logic [1:0]                   opnd_valid;
  } p_buf_slot_t;

  // Memory ops take priority over multiply/divide; everything else is ALU
  function automatic iq_class_e iq_route(input logic [LSU_TYPE_W-1:0] lsu_type,
                                         input logic [MDU_TYPE_W-1:0] mdu_type);
    iq_class_e cls;
    if (lsu_type != '0)      cls = IQ_LSU;
    else if (mdu_type != '0) cls = IQ_MDU;
    else                     cls = IQ_ALU;
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/p_operand_capture.sv
`default_nettype none
// ============================================================================
//  Module   : p_operand_capture
//  Purpose  : One source operand: compares its producer tag against every
//             CDB port and, if the operand is still pending, takes the
//             broadcast value and marks it valid.
//  Revision : 1.0  initial release
// ============================================================================
module p_operand_capture #(
  parameter int CDB_PORTS  = 2,
  parameter int ROB_WIDTH  = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ROB_WIDTH-1:0]                  src_preg_i,
  input  logic [DATA_WIDTH-1:0]                 data_i,
  input  logic                                  valid_i,
  input  logic [CDB_PORTS-1:0]                  cdb_valid_i,
  input  logic [CDB_PORTS-1:0][ROB_WIDTH-1:0]   cdb_robid_i,
  input  logic [CDB_PORTS-1:0][DATA_WIDTH-1:0]  cdb_data_i,
  output logic [DATA_WIDTH-1:0]                 data_o,
  output logic                                  valid_o
);

  // Scan ports from highest to lowest so the lowest-numbered hit is applied last and wins
  always_comb begin
    data_o  = data_i;
    valid_o = valid_i;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (!valid_i && cdb_valid_i[p] && (cdb_robid_i[p] == src_preg_i)) begin
        data_o  = cdb_data_i[p];
        valid_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/p_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : p_dispatch
//  Purpose  : P stage. Holds one renamed pair from R, resolves the intra-pair
//             RAW dependency, snoops the CDB for pending operands and
//             dispatches the pair all-or-nothing into the ALU/MDU/LSU issue
//             queues while writing both ROB entries.
//  Revision : 1.0  initial release
// ============================================================================
module p_dispatch
  import p_dispatch_pkg::*;
#(
  parameter int CDB_PORTS  = CDB_N,
  parameter int ROB_WIDTH  = ROB_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  r_valid_i,
  output logic                                  r_ready_o,
  input  r_p_pkg_t                              r_data_i,
  input  logic                                  flush_i,
  input  logic [CDB_PORTS-1:0]                  cdb_valid_i,
  input  logic [CDB_PORTS-1:0][ROB_WIDTH-1:0]   cdb_robid_i,
  input  logic [CDB_PORTS-1:0][DATA_WIDTH-1:0]  cdb_data_i,
  output p_iq_pkg_t [1:0]                       iq_pkt_o,
  output logic [1:0]                            alu_valid_o,
  output logic [1:0]                            mdu_valid_o,
  output logic [1:0]                            lsu_valid_o,
  input  logic                                  alu_ready_i,
  input  logic                                  mdu_ready_i,
  input  logic                                  lsu_ready_i,
  output logic [1:0]                            rob_we_o,
  output logic [1:0][ROB_WIDTH-1:0]             rob_widx_o,
  output rob_entry_t [1:0]                      rob_wdata_o
);

  buf_state_e        state_q, state_d;
  p_buf_slot_t [1:0] buf_q, buf_d;

  logic       full;
  logic [1:0] live;
  iq_class_e  slot_cls [2];
  logic       need_alu, need_mdu, need_lsu;
  logic       drain, dispatch, ready, accept;

  // Incoming operands after hazard/immediate resolution, before CDB capture
  logic [ROB_WIDTH-1:0]  in_src_preg  [2][2];
  logic [DATA_WIDTH-1:0] in_data      [2][2];
  logic                  in_valid     [2][2];
  // Capture results for the incoming pair and for the buffered pair
  logic [DATA_WIDTH-1:0] in_cap_data  [2][2];
  logic                  in_cap_valid [2][2];
  logic [DATA_WIDTH-1:0] buf_cap_data [2][2];
  logic                  buf_cap_valid[2][2];

  // Slot 0 never depends on a same-pair producer, so its source arch regs are not consulted
  logic [2*AREG_W-1:0]   unused_src_areg;
  assign unused_src_areg = r_data_i.slot[0].src_areg;

  // Buffer occupancy, per-class demand and the handshake with R
  always_comb begin
    full     = (state_q == ST_FULL);
    need_alu = 1'b0;
    need_mdu = 1'b0;
    need_lsu = 1'b0;
    live     = 2'b00;
    for (int s = 0; s < 2; s++) begin
      slot_cls[s] = iq_route(buf_q[s].lsu_type, buf_q[s].mdu_type);
      live[s]     = full & buf_q[s].r_valid;
      if (live[s]) begin
        case (slot_cls[s])
          IQ_ALU:  need_alu = 1'b1;
          IQ_MDU:  need_mdu = 1'b1;
          default: need_lsu = 1'b1;
        endcase
      end
    end
    drain    = full & (~need_alu | alu_ready_i) & (~need_mdu | mdu_ready_i)
                    & (~need_lsu | lsu_ready_i);
    dispatch = drain & ~flush_i;
    ready    = (~full | drain) & ~flush_i;
    accept   = r_valid_i & ready;
  end

  assign r_ready_o = ready;

  // Intra-pair RAW redirect for slot 1, then immediate override of operand 1
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 2; k++) begin
        in_src_preg[s][k] = r_data_i.slot[s].src_preg[k];
        in_data[s][k]     = r_data_i.slot[s].arf_data[k];
        in_valid[s][k]    = r_data_i.slot[s].data_valid[k];
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (r_data_i.slot[0].w_reg && (r_data_i.slot[0].areg != '0) &&
          (r_data_i.slot[1].src_areg[k] == r_data_i.slot[0].areg)) begin
        in_src_preg[1][k] = r_data_i.slot[0].preg;
        in_valid[1][k]    = 1'b0;
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (r_data_i.slot[s].use_imm) begin
        in_data[s][1]  = r_data_i.slot[s].data_imm;
        in_valid[s][1] = 1'b1;
      end
    end
  end

  generate
    for (genvar s = 0; s < 2; s++) begin : g_slot
      for (genvar k = 0; k < 2; k++) begin : g_opnd
        p_operand_capture #(
          .CDB_PORTS  (CDB_PORTS),
          .ROB_WIDTH  (ROB_WIDTH),
          .DATA_WIDTH (DATA_WIDTH)
        ) u_in_cap (
          .src_preg_i  (in_src_preg[s][k]),
          .data_i      (in_data[s][k]),
          .valid_i     (in_valid[s][k]),
          .cdb_valid_i (cdb_valid_i),
          .cdb_robid_i (cdb_robid_i),
          .cdb_data_i  (cdb_data_i),
          .data_o      (in_cap_data[s][k]),
          .valid_o     (in_cap_valid[s][k])
        );

        p_operand_capture #(
          .CDB_PORTS  (CDB_PORTS),
          .ROB_WIDTH  (ROB_WIDTH),
          .DATA_WIDTH (DATA_WIDTH)
        ) u_buf_cap (
          .src_preg_i  (buf_q[s].src_preg[k]),
          .data_i      (buf_q[s].opnd[k]),
          .valid_i     (buf_q[s].opnd_valid[k]),
          .cdb_valid_i (cdb_valid_i),
          .cdb_robid_i (cdb_robid_i),
          .cdb_data_i  (cdb_data_i),
          .data_o      (buf_cap_data[s][k]),
          .valid_o     (buf_cap_valid[s][k])
        );
      end
    end
  endgenerate

  // Next buffer state: flush wins, then a new pair, then a drain; otherwise keep snooping
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    if (full) begin
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < 2; k++) begin
          buf_d[s].opnd[k]       = buf_cap_data[s][k];
          buf_d[s].opnd_valid[k] = buf_cap_valid[s][k];
        end
      end
    end
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_FULL;
      for (int s = 0; s < 2; s++) begin
        buf_d[s].r_valid  = r_data_i.slot[s].r_valid;
        buf_d[s].pc       = r_data_i.slot[s].pc;
        buf_d[s].areg     = r_data_i.slot[s].areg;
        buf_d[s].preg     = r_data_i.slot[s].preg;
        buf_d[s].w_reg    = r_data_i.slot[s].w_reg;
        buf_d[s].w_mem    = r_data_i.slot[s].w_mem;
        buf_d[s].check    = r_data_i.slot[s].check;
        buf_d[s].alu_type = r_data_i.slot[s].alu_type;
        buf_d[s].mdu_type = r_data_i.slot[s].mdu_type;
        buf_d[s].lsu_type = r_data_i.slot[s].lsu_type;
        for (int k = 0; k < 2; k++) begin
          buf_d[s].src_preg[k]   = in_src_preg[s][k];
          buf_d[s].opnd[k]       = in_cap_data[s][k];
          buf_d[s].opnd_valid[k] = in_cap_valid[s][k];
        end
      end
    end else if (drain) begin
      state_d = ST_EMPTY;
    end
  end

  // Pair register and occupancy state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // Queue pushes, ROB writes and the shared slot packets (captured data forwarded)
  always_comb begin
    iq_pkt_o    = '0;
    alu_valid_o = 2'b00;
    mdu_valid_o = 2'b00;
    lsu_valid_o = 2'b00;
    rob_we_o    = 2'b00;
    rob_widx_o  = '0;
    rob_wdata_o = '0;
    for (int s = 0; s < 2; s++) begin
      alu_valid_o[s] = dispatch & live[s] & (slot_cls[s] == IQ_ALU);
      mdu_valid_o[s] = dispatch & live[s] & (slot_cls[s] == IQ_MDU);
      lsu_valid_o[s] = dispatch & live[s] & (slot_cls[s] == IQ_LSU);
      rob_we_o[s]    = dispatch & live[s];
      if (full) begin
        iq_pkt_o[s].pc       = buf_q[s].pc;
        iq_pkt_o[s].preg     = buf_q[s].preg;
        iq_pkt_o[s].areg     = buf_q[s].areg;
        iq_pkt_o[s].w_reg    = buf_q[s].w_reg;
        iq_pkt_o[s].w_mem    = buf_q[s].w_mem;
        iq_pkt_o[s].alu_type = buf_q[s].alu_type;
        iq_pkt_o[s].mdu_type = buf_q[s].mdu_type;
        iq_pkt_o[s].lsu_type = buf_q[s].lsu_type;
        for (int k = 0; k < 2; k++) begin
          iq_pkt_o[s].src_preg[k]   = buf_q[s].src_preg[k];
          iq_pkt_o[s].opnd[k]       = buf_cap_data[s][k];
          iq_pkt_o[s].opnd_valid[k] = buf_cap_valid[s][k];
        end
        rob_widx_o[s]           = buf_q[s].preg;
        rob_wdata_o[s].pc       = buf_q[s].pc;
        rob_wdata_o[s].areg     = buf_q[s].areg;
        rob_wdata_o[s].w_reg    = buf_q[s].w_reg;
        rob_wdata_o[s].w_mem    = buf_q[s].w_mem;
        rob_wdata_o[s].check    = buf_q[s].check;
        rob_wdata_o[s].complete = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_p_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_p_dispatch
//  Purpose  : Randomised and directed stimulus for p_dispatch with a
//             pair-level reference model and a dispatch scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_p_dispatch;
  import p_dispatch_pkg::*;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         r_valid_i;
  logic                         r_ready_o;
  r_p_pkg_t                     r_data_i;
  logic                         flush_i;
  logic [1:0]                   cdb_valid_i;
  logic [1:0][ROB_W-1:0]        cdb_robid_i;
  logic [1:0][DATA_W-1:0]       cdb_data_i;
  p_iq_pkg_t [1:0]              iq_pkt_o;
  logic [1:0]                   alu_valid_o, mdu_valid_o, lsu_valid_o;
  logic                         alu_ready_i, mdu_ready_i, lsu_ready_i;
  logic [1:0]                   rob_we_o;
  logic [1:0][ROB_W-1:0]        rob_widx_o;
  rob_entry_t [1:0]             rob_wdata_o;

  p_dispatch dut (
    .clk(clk), .rst_n(rst_n), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o),
    .r_data_i(r_data_i), .flush_i(flush_i), .cdb_valid_i(cdb_valid_i),
    .cdb_robid_i(cdb_robid_i), .cdb_data_i(cdb_data_i), .iq_pkt_o(iq_pkt_o),
    .alu_valid_o(alu_valid_o), .mdu_valid_o(mdu_valid_o), .lsu_valid_o(lsu_valid_o),
    .alu_ready_i(alu_ready_i), .mdu_ready_i(mdu_ready_i), .lsu_ready_i(lsu_ready_i),
    .rob_we_o(rob_we_o), .rob_widx_o(rob_widx_o), .rob_wdata_o(rob_wdata_o)
  );

  always #5 clk = ~clk;

  // Expected view of one instruction (cls: 0 ALU, 1 MDU, 2 LSU)
  typedef struct packed {
    logic              live;
    logic [31:0]       pc;
    logic [4:0]        areg;
    logic [5:0]        preg;
    logic              w_reg, w_mem, chk;
    logic [1:0]        cls;
    logic [1:0][5:0]   src;
    logic [1:0][31:0]  data;
    logic [1:0]        val;
  } exp_slot_t;
  typedef exp_slot_t [1:0] exp_pair_t;

  exp_pair_t pend[$];   // pair held in P
  exp_pair_t sb[$];     // pairs expected to dispatch this cycle

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int slot, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s slot%0d: got %0h expected %0h at %0t", name, slot, act, exp, $time);
    end
  endtask

  function automatic exp_pair_t cdb_apply(input exp_pair_t p);
    exp_pair_t q = p;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 2; k++)
        if (!q[s].val[k])
          for (int c = 0; c < 2; c++)
            if (cdb_valid_i[c] && cdb_robid_i[c] == q[s].src[k]) begin
              q[s].data[k] = cdb_data_i[c];
              q[s].val[k]  = 1'b1;
              break;
            end
    return q;
  endfunction

  function automatic exp_pair_t from_r(input r_p_pkg_t r);
    exp_pair_t p;
    for (int s = 0; s < 2; s++) begin
      p[s].live  = r.slot[s].r_valid;
      p[s].pc    = r.slot[s].pc;
      p[s].areg  = r.slot[s].areg;
      p[s].preg  = r.slot[s].preg;
      p[s].w_reg = r.slot[s].w_reg;
      p[s].w_mem = r.slot[s].w_mem;
      p[s].chk   = r.slot[s].check;
      p[s].cls   = (r.slot[s].lsu_type != 0) ? 2'd2 : (r.slot[s].mdu_type != 0) ? 2'd1 : 2'd0;
      for (int k = 0; k < 2; k++) begin
        p[s].src[k]  = r.slot[s].src_preg[k];
        p[s].data[k] = r.slot[s].arf_data[k];
        p[s].val[k]  = r.slot[s].data_valid[k];
        if (s == 1 && r.slot[0].w_reg && r.slot[0].areg != 0 && r.slot[1].src_areg[k] == r.slot[0].areg) begin
          p[s].src[k] = r.slot[0].preg;
          p[s].val[k] = 1'b0;
        end
      end
      if (r.slot[s].use_imm) begin
        p[s].data[1] = r.slot[s].data_imm;
        p[s].val[1]  = 1'b1;
      end
    end
    return cdb_apply(p);
  endfunction

  // Reference model: evaluates each cycle with inputs settled
  initial begin : model
    exp_pair_t fwd;
    logic need_ok, any_live, exp_drain, exp_ready;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
        continue;
      end
      need_ok  = 1'b1;
      any_live = 1'b0;
      fwd      = '0;
      if (pend.size() > 0) begin
        fwd = cdb_apply(pend[0]);
        for (int s = 0; s < 2; s++)
          if (fwd[s].live) begin
            any_live = 1'b1;
            case (fwd[s].cls)
              2'd0:    need_ok &= alu_ready_i;
              2'd1:    need_ok &= mdu_ready_i;
              default: need_ok &= lsu_ready_i;
            endcase
          end
      end
      exp_drain = (pend.size() > 0) && need_ok && !flush_i;
      exp_ready = ((pend.size() == 0) || need_ok) && !flush_i;
      chk("r_ready", 0, 64'(r_ready_o), 64'(exp_ready));
      if (pend.size() == 0) chk("iq_pkt_idle_zero", 0, 64'(|iq_pkt_o), 64'd0);
      if (exp_drain && any_live) sb.push_back(fwd);
      if (flush_i) pend.delete();
      else begin
        if (exp_drain) pend.delete(0);
        else if (pend.size() > 0) pend[0] = fwd;
        if (r_valid_i && exp_ready) pend.push_back(from_r(r_data_i));
      end
    end
  end

  // Monitor: pops an expected pair whenever the DUT pushes into the queues / ROB
  initial begin : monitor
    exp_pair_t e;
    logic presented;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) continue;
      presented = |{rob_we_o, alu_valid_o, mdu_valid_o, lsu_valid_o};
      if (sb.size() == 0) begin
        chk("no_dispatch", 0, 64'(presented), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("dispatch_present", 0, 64'(presented), 64'd1);
        for (int s = 0; s < 2; s++) begin
          chk("rob_we",    s, 64'(rob_we_o[s]),    64'(e[s].live));
          chk("alu_valid", s, 64'(alu_valid_o[s]), 64'(e[s].live && e[s].cls == 2'd0));
          chk("mdu_valid", s, 64'(mdu_valid_o[s]), 64'(e[s].live && e[s].cls == 2'd1));
          chk("lsu_valid", s, 64'(lsu_valid_o[s]), 64'(e[s].live && e[s].cls == 2'd2));
          if (e[s].live) begin
            chk("rob_widx", s, 64'(rob_widx_o[s]), 64'(e[s].preg));
            chk("rob_pc",   s, 64'(rob_wdata_o[s].pc), 64'(e[s].pc));
            chk("rob_flags", s,
                64'({rob_wdata_o[s].areg, rob_wdata_o[s].w_reg, rob_wdata_o[s].w_mem,
                     rob_wdata_o[s].check, rob_wdata_o[s].complete}),
                64'({e[s].areg, e[s].w_reg, e[s].w_mem, e[s].chk, 1'b0}));
            chk("iq_pc",   s, 64'(iq_pkt_o[s].pc),   64'(e[s].pc));
            chk("iq_preg", s, 64'(iq_pkt_o[s].preg), 64'(e[s].preg));
            for (int k = 0; k < 2; k++) begin
              chk("iq_src_preg",   s, 64'(iq_pkt_o[s].src_preg[k]),   64'(e[s].src[k]));
              chk("iq_opnd_valid", s, 64'(iq_pkt_o[s].opnd_valid[k]), 64'(e[s].val[k]));
              if (e[s].val[k]) chk("iq_opnd", s, 64'(iq_pkt_o[s].opnd[k]), 64'(e[s].data[k]));
            end
          end
        end
      end
    end
  end

  function automatic r_p_slot_t rand_slot();
    r_p_slot_t s = '0;
    s.r_valid  = ($urandom_range(0, 7) != 0);
    s.pc       = $urandom;
    s.areg     = 5'($urandom_range(0, 7));
    s.preg     = 6'($urandom);
    s.w_reg    = 1'($urandom_range(0, 1));
    s.w_mem    = 1'($urandom_range(0, 1));
    s.check    = 1'($urandom_range(0, 1));
    s.alu_type = 4'($urandom);
    case ($urandom_range(0, 3))
      0: ;
      1: s.mdu_type = 3'($urandom_range(1, 7));
      2: s.lsu_type = 3'($urandom_range(1, 7));
      default: begin
        s.mdu_type = 3'($urandom_range(1, 7));
        s.lsu_type = 3'($urandom_range(1, 7));
      end
    endcase
    for (int k = 0; k < 2; k++) begin
      s.src_areg[k]   = 5'($urandom_range(0, 7));
      s.src_preg[k]   = 6'($urandom_range(0, 15));
      s.arf_data[k]   = $urandom;
      s.data_valid[k] = 1'($urandom_range(0, 1));
    end
    s.use_imm  = ($urandom_range(0, 3) == 0);
    s.data_imm = $urandom;
    return s;
  endfunction

  function automatic r_p_slot_t plain_slot(input logic [5:0] preg, input logic [2:0] mdu, input logic [2:0] lsu);
    r_p_slot_t s = '0;
    s.r_valid = 1'b1;
    s.pc = {26'h0, preg} << 2;
    s.preg = preg;
    s.mdu_type = mdu;
    s.lsu_type = lsu;
    s.data_valid = 2'b11;
    s.arf_data[0] = 32'h1000 + 32'(preg);
    s.arf_data[1] = 32'h2000 + 32'(preg);
    return s;
  endfunction

  task automatic idle_inputs();
    r_valid_i   = 1'b0;
    flush_i     = 1'b0;
    cdb_valid_i = 2'b00;
    cdb_robid_i = '0;
    cdb_data_i  = '0;
    alu_ready_i = 1'b1;
    mdu_ready_i = 1'b1;
    lsu_ready_i = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin : driver
    rst_n    = 1'b0;
    r_data_i = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step();

    // ALU + LSU pair, all operands ready
    r_valid_i = 1'b1;
    r_data_i.slot[0] = plain_slot(6'd3, 3'd0, 3'd0);
    r_data_i.slot[1] = plain_slot(6'd4, 3'd0, 3'd2);
    step();
    idle_inputs();
    repeat (2) step();

    // Slot 1 reads r5 written by slot 0 (preg 12); producer broadcasts next cycle
    r_valid_i = 1'b1;
    r_data_i.slot[0] = plain_slot(6'd12, 3'd0, 3'd0);
    r_data_i.slot[0].areg  = 5'd5;
    r_data_i.slot[0].w_reg = 1'b1;
    r_data_i.slot[1] = plain_slot(6'd13, 3'd0, 3'd0);
    r_data_i.slot[1].src_areg[0] = 5'd5;
    r_data_i.slot[1].src_preg[0] = 6'd40;
    step();
    idle_inputs();
    cdb_valid_i = 2'b01;
    cdb_robid_i[0] = 6'd12;
    cdb_data_i[0]  = 32'h0000DEAD;
    step();
    idle_inputs();
    step();

    // MDU pair stalled three cycles by mdu_ready_i
    r_valid_i = 1'b1;
    r_data_i.slot[0] = plain_slot(6'd20, 3'd1, 3'd0);
    r_data_i.slot[1] = plain_slot(6'd21, 3'd3, 3'd0);
    step();
    idle_inputs();
    mdu_ready_i = 1'b0;
    repeat (3) step();
    mdu_ready_i = 1'b1;
    repeat (2) step();

    // Back-to-back pairs with every queue ready
    for (int i = 0; i < 6; i++) begin
      r_valid_i = 1'b1;
      r_data_i.slot[0] = plain_slot(6'(30 + 2 * i), 3'(i % 2), 3'd0);
      r_data_i.slot[1] = plain_slot(6'(31 + 2 * i), 3'd0, 3'(i % 3));
      step();
    end
    idle_inputs();
    step();

    // Flush while FULL and ready, with a new pair offered in the flush cycle
    r_valid_i = 1'b1;
    r_data_i.slot[0] = plain_slot(6'd50, 3'd0, 3'd0);
    r_data_i.slot[1] = plain_slot(6'd51, 3'd0, 3'd0);
    step();
    flush_i = 1'b1;
    r_data_i.slot[0] = plain_slot(6'd52, 3'd0, 3'd0);
    step();
    idle_inputs();
    repeat (2) step();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      r_valid_i   = ($urandom_range(0, 9) < 7);
      r_data_i.slot[0] = rand_slot();
      r_data_i.slot[1] = rand_slot();
      flush_i     = ($urandom_range(0, 39) == 0);
      alu_ready_i = ($urandom_range(0, 4) != 0);
      mdu_ready_i = ($urandom_range(0, 3) != 0);
      lsu_ready_i = ($urandom_range(0, 4) != 0);
      for (int c = 0; c < 2; c++) begin
        cdb_valid_i[c] = 1'($urandom_range(0, 1));
        cdb_robid_i[c] = 6'($urandom_range(0, 15));
        cdb_data_i[c]  = $urandom;
      end
      step();
    end
    idle_inputs();
    repeat (4) step();
    chk("scoreboard_drained", 0, 64'(sb.size()), 64'd0);
    chk("pair_drained", 0, 64'(pend.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
